// File: rtl/seq_recognizer_param.sv
// seq_recognizer_param
//   Serial pattern recognizer. It watches the bit stream on x, taking a bit
//   only when en=1, and compares the last N accepted bits with a pattern that
//   can be loaded at run time. A match raises z for one cycle and increments a
//   saturating match counter. Matches can share bits (OVERLAP=1), or the bit
//   history can be discarded after each match (OVERLAP=0).
//
// Ports
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   en           in   1      qualifies x; x is ignored while en=0
//   x            in   1      serial data bit
//   load         in   1      replace the pattern with pattern_in and restart history
//   pattern_in   in   N      new pattern, MSB = first bit of the sequence
//   clr_count    in   1      clear match_count and count_sat
//   z            out  1      registered one-cycle match pulse
//   match_count  out  CNT_W  saturating number of matches since reset/clear
//   count_sat    out  1      sticky flag: match_count reached all-ones
//   pattern      out  N      currently active pattern
module seq_recognizer_param #(
  parameter int             N               = 4,
  parameter logic [N-1:0]   DEFAULT_PATTERN = 4'b0111,
  parameter bit             OVERLAP         = 1'b1,
  parameter int             CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             clr_count,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic [N-1:0]     pattern
);

  localparam int            FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [N-1:0]     hist;
  logic [FW-1:0]    fill;
  logic [0:0]       state;

  logic [N-1:0]     hist_shift;
  logic [FW-1:0]    fill_inc;
  logic             accept;
  logic             match;
  logic [CNT_W-1:0] count_next;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  // Stage 0: next history and match decision for the bit presented this cycle
  always_comb begin
    hist_shift = {hist[N-2:0], x};
    // RUN means the history already holds N valid bits, so fill stays at N.
    fill_inc   = (state == RUN) ? fill : fill + FW'(1);
    accept     = en & ~load;
    // Requiring a full history keeps zero-initialised or stale bits from
    // completing a match before N real bits have arrived.
    match      = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern);
    count_next = sat_inc(match_count);
  end

  // Stage 1: history, fill/state, pattern and match pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern <= DEFAULT_PATTERN;
      hist    <= '0;
      fill    <= '0;
      state   <= FILL;
      z       <= 1'b0;
    end else if (load) begin
      // A bit offered in the load cycle is dropped on purpose.
      pattern <= pattern_in;
      hist    <= '0;
      fill    <= '0;
      state   <= FILL;
      z       <= 1'b0;
    end else if (en) begin
      z <= match;
      if (match && !OVERLAP) begin
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else begin
        hist  <= hist_shift;
        fill  <= fill_inc;
        state <= (fill_inc == FILL_FULL) ? RUN : FILL;
      end
    end else begin
      z <= 1'b0;
    end
  end

  // Stage 1: match counter; a clear in the same cycle as a match wins
  always_ff @(posedge clock) begin
    if (reset || clr_count) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (match) begin
      match_count <= count_next;
      count_sat   <= count_sat | (&count_next);
    end
  end

endmodule

// File: tb/tb_seq_recognizer_param.sv
module tb_seq_recognizer_param;

  logic       clock = 1'b0;
  logic       reset, en, x, load, clr_count;
  logic [3:0] pattern_in;

  logic       za, zb, zc, sa, sb, sc;
  logic [7:0] ca, cb;
  logic [1:0] cc;
  logic [3:0] pa, pb, pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Overlapping, default pattern 0111, 8-bit counter
  seq_recognizer_param #(.N(4), .DEFAULT_PATTERN(4'b0111), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .clr_count(clr_count), .z(za), .match_count(ca), .count_sat(sa), .pattern(pa));

  // Non-overlapping variant
  seq_recognizer_param #(.N(4), .DEFAULT_PATTERN(4'b0111), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .clr_count(clr_count), .z(zb), .match_count(cb), .count_sat(sb), .pattern(pb));

  // Default pattern 0001, 2-bit counter for saturation
  seq_recognizer_param #(.N(4), .DEFAULT_PATTERN(4'b0001), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .clr_count(clr_count), .z(zc), .match_count(cc), .count_sat(sc), .pattern(pc));

  typedef struct {
    logic       en;
    logic       x;
    logic       load;
    logic [3:0] pin;
    logic       clr;
    logic       za;
    logic       zb;
    logic [7:0] ca;
    logic [7:0] cb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic xx, input logic ld, input logic [3:0] p,
                     input logic c, input logic eza, input logic ezb,
                     input logic [7:0] eca, input logic [7:0] ecb);
    vec_t v;
    v.en = e; v.x = xx; v.load = ld; v.pin = p; v.clr = c;
    v.za = eza; v.zb = ezb; v.ca = eca; v.cb = ecb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic xx, input logic ld, input logic [3:0] p,
                     input logic c);
    en = e; x = xx; load = ld; pattern_in = p; clr_count = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; pattern_in = 4'h0; clr_count = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    // en x ld pin clr | za zb ca cb
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);  // 0111 stream
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);  // gap case
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);  // en=0 -> z low
    add(1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);  // load 1010
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd3);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd3);  // overlap only on a
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd3);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0);  // clear beats match, z pulses
    add(1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);  // load 0111
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);  // load drops x=1
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);  // hist=0111 but fill=3
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1);

    do_reset();
    chk("reset_z_a", 32'(za), 32'd0);
    chk("reset_z_b", 32'(zb), 32'd0);
    chk("reset_cnt_a", 32'(ca), 32'd0);
    chk("reset_sat_a", 32'(sa), 32'd0);
    chk("reset_pat_a", 32'(pa), 32'h7);
    chk("reset_pat_c", 32'(pc), 32'h1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].en, tbl[i].x, tbl[i].load, tbl[i].pin, tbl[i].clr);
      chk($sformatf("row%0d_z_a", i), 32'(za), 32'(tbl[i].za));
      chk($sformatf("row%0d_z_b", i), 32'(zb), 32'(tbl[i].zb));
      chk($sformatf("row%0d_cnt_a", i), 32'(ca), 32'(tbl[i].ca));
      chk($sformatf("row%0d_cnt_b", i), 32'(cb), 32'(tbl[i].cb));
    end
    chk("pat_a_after_load", 32'(pa), 32'h7);

    // Pattern 0001 from reset: a lone first 1 must not match a zero history
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("c_first_bit_z", 32'(zc), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("c_fill_z", 32'(zc), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("c_fill4_z", 32'(zc), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("c_match1_z", 32'(zc), 32'd1);
    chk("c_match1_cnt", 32'(cc), 32'd1);
    chk("c_match1_sat", 32'(sc), 32'd0);

    // Three more matches on the 2-bit counter: 2, 3 (saturated), 3 held
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      chk($sformatf("c_gap%0d_z", k), 32'(zc), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      chk($sformatf("c_m%0d_z", k), 32'(zc), 32'd1);
      chk($sformatf("c_m%0d_cnt", k), 32'(cc), (k == 0) ? 32'd2 : 32'd3);
      chk($sformatf("c_m%0d_sat", k), 32'(sc), (k == 0) ? 32'd0 : 32'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("c_clr_cnt", 32'(cc), 32'd0);
    chk("c_clr_sat", 32'(sc), 32'd0);
    chk("c_clr_z", 32'(zc), 32'd0);

    // Mid-stream reset with a partial 0111 in flight
    cyc(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    chk("c_loaded_pat", 32'(pc), 32'h7);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("mid_rst_z_a", 32'(za), 32'd0);
    chk("mid_rst_z_b", 32'(zb), 32'd0);
    chk("mid_rst_z_c", 32'(zc), 32'd0);
    chk("mid_rst_cnt_a", 32'(ca), 32'd0);
    chk("mid_rst_cnt_c", 32'(cc), 32'd0);
    chk("mid_rst_sat_c", 32'(sc), 32'd0);
    chk("mid_rst_pat_a", 32'(pa), 32'h7);
    chk("mid_rst_pat_c", 32'(pc), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("mid_rst_z_a_next", 32'(za), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
